// File: rtl/float_type_stats_pkg.sv
// Shared definitions for the float-class statistics block: one-hot class
// codes (the classifier uses the same values), FSM states and result selects.
package float_type_stats_pkg;

    localparam int NUM_CLASSES = 5;

    localparam logic [4:0] FT_ZERO      = 5'b00001;
    localparam logic [4:0] FT_NORMAL    = 5'b00010;
    localparam logic [4:0] FT_SUBNORMAL = 5'b00100;
    localparam logic [4:0] FT_INF       = 5'b01000;
    localparam logic [4:0] FT_NAN       = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam logic [2:0] RD_ZERO      = 3'd0;
    localparam logic [2:0] RD_NORMAL    = 3'd1;
    localparam logic [2:0] RD_SUBNORMAL = 3'd2;
    localparam logic [2:0] RD_INF       = 3'd3;
    localparam logic [2:0] RD_NAN       = 3'd4;
    localparam logic [2:0] RD_ERR       = 3'd5;
    localparam logic [2:0] RD_SAMPLE    = 3'd6;

endpackage

// File: rtl/float_type_stats_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module float_type_stats_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc until all-ones; clear has priority over increment.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/float_type_stats.sv
// Per-frame tally of IEEE-754 class codes from the float classifier stream,
// with malformed-code counting and first-NaN capture.
module float_type_stats
    import float_type_stats_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      num,
    input  logic [4:0]       float_type,
    output logic             busy,
    output logic             done,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             nan_seen,
    output logic [31:0]      first_nan
);

    localparam int SW = $clog2(FRAME_LEN + 1);
    localparam logic [SW-1:0] LAST_IDX = SW'(FRAME_LEN - 1);

    state_t           state;
    logic [SW-1:0]    sample_cnt;
    logic [CNT_W-1:0] class_cnt [NUM_CLASSES];
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] sample_ext;
    logic             accept;
    logic             clr;
    logic             legal;

    assign in_ready = (state == ST_COLLECT);
    assign busy     = (state == ST_COLLECT);
    assign done     = (state == ST_REPORT);
    assign accept   = in_valid && (state == ST_COLLECT);
    assign clr      = start && (state == ST_IDLE);
    assign legal    = $onehot(float_type);

    // Frame sequencing: IDLE waits for start, COLLECT counts accepts, REPORT lasts one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start) state <= ST_COLLECT;
                ST_COLLECT: if (accept && (sample_cnt == LAST_IDX)) state <= ST_REPORT;
                ST_REPORT:  state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Samples accepted in the current frame; frame length bounds it, so no saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (clr) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + SW'(1);
        end
    end

    // Latch the operand of the first NaN accepted in the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nan_seen  <= 1'b0;
            first_nan <= '0;
        end else if (clr) begin
            nan_seen  <= 1'b0;
            first_nan <= '0;
        end else if (accept && (float_type == FT_NAN) && !nan_seen) begin
            nan_seen  <= 1'b1;
            first_nan <= num;
        end
    end

    // One saturating counter per class; a class counts only on its exact one-hot code.
    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_class
        localparam logic [4:0] CODE = 5'(1 << i);
        float_type_stats_sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .inc   (accept && (float_type == CODE)),
            .cnt   (class_cnt[i])
        );
    end

    float_type_stats_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (accept && !legal),
        .cnt   (err_cnt)
    );

    // Fit sample_cnt into the result width: zero-extend or keep the low bits.
    if (SW >= CNT_W) begin : g_trunc
        assign sample_ext = sample_cnt[CNT_W-1:0];
    end else begin : g_ext
        assign sample_ext = {{(CNT_W - SW){1'b0}}, sample_cnt};
    end

    // Result read-back mux, combinational from rd_sel.
    // NOTE: default assignment first so no path leaves rd_data unassigned (no latch).
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            RD_ZERO:      rd_data = class_cnt[0];
            RD_NORMAL:    rd_data = class_cnt[1];
            RD_SUBNORMAL: rd_data = class_cnt[2];
            RD_INF:       rd_data = class_cnt[3];
            RD_NAN:       rd_data = class_cnt[4];
            RD_ERR:       rd_data = err_cnt;
            RD_SAMPLE:    rd_data = sample_ext;
            default:      rd_data = '0;
        endcase
    end

endmodule
